// File: rtl/rf_phoenix_fifo_param.sv
// rf_phoenix_fifo_param: parametrised synchronous FIFO with registered or fall-through read,
// threshold flags, sticky overflow/underflow and synchronous flush.
module rf_phoenix_fifo_param #(
    parameter int WID = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter bit FWFT = 1'b0,
    parameter int AF_LEVEL = (1 << DEPTH_LOG2) - 4,
    parameter int AE_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [WID-1:0]        di,
    input  logic                  rd,
    output logic [WID-1:0]        dout,
    output logic                  v,
    output logic [DEPTH_LOG2:0]   cnt,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ovf,
    output logic                  unf
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW = DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    logic [WID-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [WID-1:0] dout_r;
    logic           v_r;
    logic           wr_acc, rd_acc;
    assign full = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign almost_full = cnt >= CW'(AF_LEVEL);
    assign almost_empty = cnt <= CW'(AE_LEVEL);
    // a read at full frees the slot the same-cycle write lands in
    assign rd_acc = rd & !empty & !clr;
    assign wr_acc = wr & (!full | rd) & !clr & !rst;
    assign dout = FWFT ? (empty ? '0 : mem[rd_ptr]) : dout_r;
    assign v = FWFT ? !empty : v_r;
    always_ff @(posedge clk)
        if (wr_acc)
            mem[wr_ptr] <= di;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            dout_r <= '0;
            v_r <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            dout_r <= '0;
            v_r <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
                dout_r <= mem[rd_ptr];
            end
            cnt <= cnt + CW'(wr_acc) - CW'(rd_acc);
            v_r <= rd_acc;
            if (wr & !wr_acc)
                ovf <= 1'b1;
            if (rd & empty)
                unf <= 1'b1;
        end
endmodule

// File: tb/tb_rf_phoenix_fifo_param.sv
// tb_rf_phoenix_fifo_param: vector-table and scoreboard bench for a depth-8 FIFO,
// running registered-read and fall-through instances side by side on the same stimulus.
module tb_rf_phoenix_fifo_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] di = '0;
    logic [31:0] dout0, dout1;
    logic        v0, v1;
    logic [3:0]  cnt0, cnt1;
    logic        full0, full1, empty0, empty1, af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          prev_cnt = 0;
    logic [31:0] exp_dout = '0;
    logic        exp_v = 1'b0;
    logic [31:0] sb [$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic        clr;
        logic [31:0] di;
        int          ecnt;
        logic        eovf;
        logic        eunf;
    } vec_t;
    vec_t vecs [$];

    rf_phoenix_fifo_param #(.WID(32), .DEPTH_LOG2(3), .FWFT(1'b0), .AF_LEVEL(6), .AE_LEVEL(2)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .di(di), .rd(rd), .dout(dout0), .v(v0), .cnt(cnt0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .ovf(ovf0), .unf(unf0));
    rf_phoenix_fifo_param #(.WID(32), .DEPTH_LOG2(3), .FWFT(1'b1), .AF_LEVEL(6), .AE_LEVEL(2)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .di(di), .rd(rd), .dout(dout1), .v(v1), .cnt(cnt1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .ovf(ovf1), .unf(unf1));

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [31:0] d,
                                input int ec, input logic eo, input logic eu);
        vec_t t;
        t.wr = w;
        t.rd = r;
        t.clr = c;
        t.di = d;
        t.ecnt = ec;
        t.eovf = eo;
        t.eunf = eu;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic chk_state(input int ec, input logic eo, input logic eu);
        chk("cnt", 32'(cnt0), 32'(ec));
        chk("full", 32'(full0), 32'(ec == 8));
        chk("empty", 32'(empty0), 32'(ec == 0));
        chk("almost_full", 32'(af0), 32'(ec >= 6));
        chk("almost_empty", 32'(ae0), 32'(ec <= 2));
        chk("ovf", 32'(ovf0), 32'(eo));
        chk("unf", 32'(unf0), 32'(eu));
        chk("v", 32'(v0), 32'(exp_v));
        chk("dout", dout0, exp_dout);
        chk("fwft_cnt", 32'(cnt1), 32'(ec));
        chk("fwft_v", 32'(v1), 32'(ec != 0));
        if (ec != 0 && sb.size() != 0)
            chk("fwft_dout", dout1, sb[0]);
    endtask

    task automatic apply(input vec_t t);
        logic wa, ra;
        wa = t.wr && (prev_cnt < 8 || t.rd) && !t.clr;
        ra = t.rd && prev_cnt > 0 && !t.clr;
        wr = t.wr;
        rd = t.rd;
        clr = t.clr;
        di = t.di;
        @(posedge clk);
        #1;
        if (t.clr) begin
            sb.delete();
            exp_dout = '0;
            exp_v = 1'b0;
        end else begin
            exp_v = ra;
            if (ra)
                exp_dout = sb.pop_front();
            if (wa)
                sb.push_back(t.di);
        end
        prev_cnt = t.ecnt;
        chk_state(t.ecnt, t.eovf, t.eunf);
        wr = 1'b0;
        rd = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 0, 0, 32'(i), i, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'hAA, 8, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h9, 8, 1, 0));
        for (int i = 7; i >= 0; i--)
            vecs.push_back(mk(0, 1, 0, 0, i, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 32'h33, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(1, 0, 0, 32'h40 + 32'(i), i, 1, 1));
        vecs.push_back(mk(1, 0, 1, 32'hEE, 0, 0, 0));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(1, 0, 0, 32'h100 + 32'(i), 1, 0, 0));
            vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        end
        #1;
        chk_state(0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_state(0, 0, 0);
        foreach (vecs[i])
            apply(vecs[i]);
        apply(mk(1, 0, 0, 32'h5, 1, 0, 0));
        chk("fwft_head_5", dout1, 32'h5);
        chk("fwft_v_after_wr", 32'(v1), 32'd1);
        apply(mk(0, 1, 0, 0, 0, 0, 0));
        chk("fwft_v_after_rd", 32'(v1), 32'd0);
        chk("fwft_empty_after_rd", 32'(empty1), 32'd1);
        apply(mk(0, 1, 0, 0, 0, 0, 1));
        apply(mk(1, 0, 0, 32'h77, 1, 0, 1));
        apply(mk(1, 0, 0, 32'h78, 2, 0, 1));
        apply(mk(0, 1, 0, 0, 1, 0, 1));
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        exp_dout = '0;
        exp_v = 1'b0;
        prev_cnt = 0;
        chk_state(0, 0, 0);
        chk("async_rst_fwft_empty", 32'(empty1), 32'd1);
        rst = 1'b0;
        apply(mk(1, 0, 0, 32'h99, 1, 0, 0));
        apply(mk(0, 1, 0, 0, 0, 0, 0));
        chk("post_rst_data", dout0, 32'h99);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/rf_phoenix_fifo_param.md
Name: rf_phoenix_fifo_param

Overview:
- Parametrised synchronous FIFO. It is the next-generation queue for rfPhoenix pipeline buffering (issue queues, memory-request queues, writeback buffers).
- Depth, data width and read mode (registered or first-word-fall-through) are configurable. Adds almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush.
- A write and a read in the same cycle are both accepted correctly, including when the FIFO is full.

Parameters:
- WID, 32, data width in bits.
- DEPTH_LOG2, 6, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (range 2..10).
- FWFT, 0, 0 = registered read (one-cycle latency); 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-4, almost_full asserted when cnt >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when cnt <= AE_LEVEL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous flush.
- wr  in  1  write request.
- di  in  WID  write data.
- rd  in  1  read request.
- dout  out  WID  read data.
- v  out  1  dout valid.
- cnt  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- full  out  1  cnt == DEPTH.
- empty  out  1  cnt == 0.
- almost_full  out  1  cnt >= AF_LEVEL.
- almost_empty  out  1  cnt <= AE_LEVEL.
- ovf  out  1  sticky overflow.
- unf  out  1  sticky underflow.

Behaviour:
- Reset (rst=1, asynchronous):
  - wr_ptr = rd_ptr = 0, cnt = 0, dout = 0, v = 0, ovf = unf = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Storage array is not reset.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is tracked in the registered cnt, not derived from the pointers, so full and empty are unambiguous.
- Read acceptance: rd_acc = rd & !empty.
- Write acceptance: wr_acc = wr & (!full | rd). When full and rd=1, the read frees a slot in the same cycle, so the write is accepted.
- On wr_acc: mem[wr_ptr] <= di; wr_ptr += 1.
- On rd_acc: rd_ptr += 1.
- cnt update: cnt <= cnt + wr_acc - rd_acc. Both accepted leaves cnt unchanged, with both pointers advancing.
- A write into an empty FIFO with rd=1 in the same cycle:
  - the read is rejected (empty) and unf sets;
  - the write is accepted and cnt becomes 1.
- Sticky flags:
  - ovf sets on wr & !wr_acc (write while full without rd);
  - unf sets on rd & empty;
  - both hold until rst or clr.
- FWFT=0:
  - on rd_acc, dout <= mem[rd_ptr] (old pointer) and v <= 1; otherwise v <= 0 and dout holds.
  - Latency is wr to readable (empty=0) 1 cycle, rd to dout 1 cycle.
- FWFT=1:
  - dout = mem[rd_ptr] (head, combinational from storage) and v = !empty.
  - rd consumes the currently shown word; the next word is visible the cycle after.
  - A word written into an empty FIFO appears on dout the cycle after the write.
- clr (synchronous):
  - pointers, cnt, ovf, unf, v and the registered dout go to 0.
  - clr has priority over wr/rd in the same cycle; those requests are dropped and do not set ovf/unf.
- Flags are combinational from cnt: full, empty, almost_full, almost_empty.
- Reset asserted mid-operation: state returns to reset values immediately, regardless of clk. Contents are treated as lost.
- No X on any output after reset. rd/wr are ignored while rst=1.

Test Plan:
- Fill/drain, WID=32, DEPTH_LOG2=3, FWFT=0:
  - write 1..8 -> full=1 and cnt=8 after the 8th write;
  - 9th write -> ovf=1, cnt stays 8;
  - 8 reads -> dout = 1..8, each one cycle after its rd with v=1;
  - then empty=1 and one extra rd -> unf=1.
- Simultaneous at full: with 8 entries, wr=rd=1 with di=0xAA -> cnt stays 8, ovf=0; after 8 further reads the last dout is 0xAA.
- Wrap-around: 20 cycles of interleaved single write/read with DEPTH=8 -> pointers wrap, data order preserved, cnt toggles 0/1, no flag errors.
- FWFT=1:
  - write 0x5 into empty -> next cycle dout=0x5, v=1;
  - rd -> following cycle v=0, empty=1.
- Thresholds, AF_LEVEL=6, AE_LEVEL=2:
  - almost_empty deasserts at cnt=3;
  - almost_full asserts at cnt=6 and deasserts on drop to 5.
- clr and rst:
  - clr with wr=1 at cnt=5 -> next cycle cnt=0, empty=1, ovf=unf=0;
  - rst pulsed mid-stream between clock edges -> outputs at reset values before the next edge.
